// File: rtl/ide_pio_engine.sv
// ide_pio_engine: parametrised ATA PIO burst engine with IORDY wait-state extension and timeout
module ide_pio_engine #(
   parameter int T_SETUP     = 1,
   parameter int T_PULSE     = 3,
   parameter int T_HOLD      = 1,
   parameter int T_RECOV     = 1,
   parameter int T_IORDY_MAX = 255,
   parameter bit USE_IORDY   = 1,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic             we,
   input  logic [4:0]       addr,
   input  logic [CNT_W-1:0] count,
   input  logic [15:0]      wdata,
   input  logic             wvalid,
   output logic             wready,
   output logic [15:0]      rdata,
   output logic             rvalid,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   input  logic [15:0]      ide_data_in,
   output logic [15:0]      ide_data_out,
   output logic             ide_data_oe,
   output logic             ide_dior,
   output logic             ide_diow,
   output logic [1:0]       ide_cs,
   output logic [2:0]       ide_da,
   input  logic             ide_iordy
);

   typedef enum logic [2:0] {IDLE, LOAD, SETUP, PULSE, WAIT, HOLD, RECOV, DONE} state_t;

   state_t           state_q, state_d;
   logic [7:0]       phase_q, phase_d, lim;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             we_q, we_d;
   logic [4:0]       addr_q, addr_d;
   logic [15:0]      wbuf_q, wbuf_d;
   logic             to_q, to_d;
   logic [1:0]       sync_q;
   logic             iordy_s, last, act, strb, cap;

   assign iordy_s = sync_q[1];
   assign timeout = to_q;

   // two-flop synchroniser for the asynchronous IORDY pin; idles ready
   always_ff @(posedge clk) begin
      if (reset) sync_q <= 2'b11;
      else       sync_q <= {sync_q[0], ide_iordy};
   end

   // next-state, burst bookkeeping and per-state phase counting
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      wbuf_d  = wbuf_q;
      to_d    = to_q;
      lim     = state_q == SETUP ? 8'(T_SETUP - 1) :
                state_q == PULSE ? 8'(T_PULSE - 1) :
                state_q == WAIT  ? 8'(T_IORDY_MAX - 1) :
                state_q == HOLD  ? 8'(T_HOLD - 1) : 8'(T_RECOV - 1);
      last    = phase_q == lim;
      case (state_q)
         IDLE:  if (req) begin
                   state_d = we ? LOAD : SETUP;
                   we_d    = we;
                   addr_d  = addr;
                   rem_d   = count == '0 ? CNT_W'(1) : count;
                   to_d    = 1'b0;
                end
         LOAD:  if (wvalid) begin
                   wbuf_d  = wdata;
                   state_d = SETUP;
                end
         SETUP: state_d = last ? PULSE : SETUP;
         PULSE: state_d = !last ? PULSE : (USE_IORDY && !iordy_s) ? WAIT : HOLD;
         WAIT:  if (iordy_s) state_d = HOLD;
                else if (last) begin
                   state_d = RECOV;
                   to_d    = 1'b1;
                end
         HOLD:  state_d = last ? RECOV : HOLD;
         RECOV: state_d = !last ? RECOV : (to_q || rem_q == '0) ? DONE : we_q ? LOAD : SETUP;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      cap     = state_d == HOLD && state_q != HOLD;
      rem_d   = cap ? rem_q - CNT_W'(1) : rem_d;
      phase_d = state_d != state_q ? 8'd0 : phase_q + 8'd1;
      act     = state_d inside {SETUP, PULSE, WAIT, HOLD};
      strb    = state_d inside {PULSE, WAIT};
   end

   // state and registered pin/handshake outputs, all decoded from next state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         phase_q      <= 8'd0;
         rem_q        <= '0;
         we_q         <= 1'b0;
         addr_q       <= 5'b11111;
         wbuf_q       <= 16'h0;
         to_q         <= 1'b0;
         ide_cs       <= 2'b11;
         ide_da       <= 3'b111;
         ide_dior     <= 1'b1;
         ide_diow     <= 1'b1;
         ide_data_oe  <= 1'b0;
         ide_data_out <= 16'h0;
         rdata        <= 16'h0;
         rvalid       <= 1'b0;
         wready       <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         rem_q        <= rem_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wbuf_q       <= wbuf_d;
         to_q         <= to_d;
         ide_cs       <= act ? addr_d[4:3] : 2'b11;
         ide_da       <= act ? addr_d[2:0] : 3'b111;
         ide_dior     <= !(strb && !we_d);
         ide_diow     <= !(strb && we_d);
         ide_data_oe  <= act && we_d;
         ide_data_out <= (act && we_d) ? wbuf_d : 16'h0;
         rdata        <= (cap && !we_d) ? ide_data_in : rdata;
         rvalid       <= cap && !we_d;
         wready       <= state_d == LOAD;
         busy         <= state_d != IDLE;
         done         <= state_d == DONE;
      end
   end

endmodule

// File: tb/tb_ide_pio_engine.sv
// tb_ide_pio_engine: scoreboard bench for the PIO engine (reads, writes, stalls, IORDY, timeout, reset)
module tb_ide_pio_engine;

   logic        clk = 0, reset = 1, req = 0, we = 0, wvalid = 0, ide_iordy = 1;
   logic [4:0]  addr = 0;
   logic [7:0]  count = 0;
   logic [15:0] wdata = 0, ide_data_in = 0;
   logic        wready, rvalid, busy, done, timeout, ide_data_oe, ide_dior, ide_diow;
   logic [15:0] rdata, ide_data_out;
   logic [1:0]  ide_cs;
   logic [2:0]  ide_da;

   ide_pio_engine #(.T_IORDY_MAX(8)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .count(count),
      .wdata(wdata), .wvalid(wvalid), .wready(wready), .rdata(rdata), .rvalid(rvalid),
      .busy(busy), .done(done), .timeout(timeout), .ide_data_in(ide_data_in),
      .ide_data_out(ide_data_out), .ide_data_oe(ide_data_oe), .ide_dior(ide_dior),
      .ide_diow(ide_diow), .ide_cs(ide_cs), .ide_da(ide_da), .ide_iordy(ide_iordy)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0, cyc = 0, t0 = 0, nrv = 0, ndone = 0, dlen = 0, wlen = 0;
   int d0, r0, dc;
   logic        wok = 1;
   logic [15:0] wcap;
   logic [15:0] rq[$], wq[$], wsrc[$];
   int          sq[$], wlq[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      logic acc;
      acc = wready && wvalid;
      @(posedge clk);
      #1;
      cyc++;
      if (acc && wsrc.size() > 0) void'(wsrc.pop_front());
      wdata = wsrc.size() > 0 ? wsrc[0] : 16'h0;
   endtask

   task automatic start(input logic w, input logic [4:0] a, input logic [7:0] n);
      we    = w;
      addr  = a;
      count = n;
      req   = 1;
      wdata = wsrc.size() > 0 ? wsrc[0] : 16'h0;
      tick();
      req   = 0;
      t0    = cyc - 1;
      we    = ~w;
      addr  = 5'b00000;
      count = 8'd7;
   endtask

   task automatic wait_done(input string tag, input int exp_cyc);
      for (int i = 0; i < 60 && !done; i++) tick();
      chk(tag, cyc - t0, exp_cyc);
   endtask

   // output monitor: pops the scoreboard on each read word and each completed strobe
   always @(negedge clk) begin
      if (rvalid) begin
         nrv++;
         if (rq.size() == 0) chk("rvalid_extra", 1, 0);
         else chk("rdata", rdata, rq.pop_front());
      end
      if (done) ndone++;
      if (ide_dior === 1'b0) dlen++;
      else if (dlen > 0) begin
         if (sq.size() == 0) chk("dior_extra", 1, 0);
         else chk("dior_len", dlen, sq.pop_front());
         dlen = 0;
      end
      if (ide_diow === 1'b0) begin
         if (wlen == 0) wcap = ide_data_out;
         wok &= ide_data_oe;
         wlen++;
      end else if (wlen > 0) begin
         if (wq.size() == 0) chk("diow_extra", 1, 0);
         else begin
            chk("diow_len", wlen, wlq.pop_front());
            chk("wdata_out", wcap, wq.pop_front());
            chk("w_oe", wok, 1);
         end
         wlen = 0;
         wok  = 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      chk("reset_state", {ide_dior, ide_diow, ide_cs, ide_da, ide_data_oe, ide_data_out, rdata, rvalid, wready, busy, done, timeout},
          {1'b1, 1'b1, 2'b11, 3'b111, 1'b0, 16'h0, 16'h0, 5'b0});
      reset = 0;
      tick();

      // single default read
      ide_data_in = 16'hA55A;
      rq.push_back(16'hA55A);
      sq.push_back(3);
      start(0, 5'b10111, 8'd1);
      for (int c = 1; c <= 8; c++) begin
         chk($sformatf("rd1_c%0d", c), {busy, done, rvalid, ide_diow, ide_dior, ide_cs, ide_da},
             {c <= 7, c == 7, c == 5, 1'b1, !(c >= 2 && c <= 4), (c <= 5) ? 2'b10 : 2'b11, 3'b111});
         tick();
      end

      // three-word write, wvalid held high
      wsrc = '{16'h1111, 16'h2222, 16'h3333};
      wq   = '{16'h1111, 16'h2222, 16'h3333};
      wlq  = '{3, 3, 3};
      d0 = ndone;
      wvalid = 1;
      start(1, 5'b01010, 8'd3);
      wait_done("wr3_done_cyc", 22);
      tick();
      tick();
      chk("wr3_ndone", ndone - d0, 1);
      chk("wr3_idle", busy, 0);

      // write with a 5-cycle wvalid stall in the second LOAD
      wsrc = '{16'hAAAA, 16'hBBBB};
      wq   = '{16'hAAAA, 16'hBBBB};
      wlq  = '{3, 3};
      start(1, 5'b10001, 8'd2);
      tick();
      for (int i = 0; i < 20 && !wready; i++) tick();
      chk("stall_load_cyc", cyc - t0, 8);
      wvalid = 0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("stall_%0d", i), {wready, ide_diow, ide_dior, ide_cs, ide_data_oe}, {1'b1, 1'b1, 1'b1, 2'b11, 1'b0});
         tick();
      end
      wvalid = 1;
      wait_done("stall_done_cyc", 20);
      wvalid = 0;
      tick();

      // IORDY held low for 4 cycles during the strobe
      ide_data_in = 16'hDEAD;
      rq.push_back(16'hC0DE);
      sq.push_back(7);
      r0 = nrv;
      start(0, 5'b10000, 8'd1);
      tick();
      ide_iordy = 0;
      repeat (4) tick();
      ide_iordy = 1;
      repeat (2) tick();
      ide_data_in = 16'hC0DE;
      wait_done("iordy_done_cyc", 11);
      chk("iordy_timeout", timeout, 0);
      tick();
      chk("iordy_nrv", nrv - r0, 1);

      // IORDY stuck low: timeout aborts a four-word burst
      ide_iordy = 0;
      repeat (2) tick();
      sq.push_back(11);
      r0 = nrv;
      d0 = ndone;
      start(0, 5'b01100, 8'd4);
      wait_done("to_done_cyc", 14);
      chk("to_flag", timeout, 1);
      repeat (4) tick();
      chk("to_held", {busy, timeout}, {1'b0, 1'b1});
      chk("to_nrv", nrv - r0, 0);
      chk("to_ndone", ndone - d0, 1);
      ide_iordy = 1;
      repeat (3) tick();
      ide_data_in = 16'h5A5A;
      rq.push_back(16'h5A5A);
      sq.push_back(3);
      start(0, 5'b01100, 8'd1);
      chk("to_cleared", timeout, 0);
      wait_done("post_to_done_cyc", 7);
      tick();

      // reset during a write strobe
      wsrc = '{16'hBEEF, 16'h0F0F};
      wq.push_back(16'hBEEF);
      wlq.push_back(2);
      wvalid = 1;
      start(1, 5'b10010, 8'd2);
      for (int i = 0; i < 20 && ide_diow; i++) tick();
      chk("rst_strobe_low", ide_diow, 0);
      tick();
      reset = 1;
      d0 = ndone;
      tick();
      reset  = 0;
      wvalid = 0;
      wsrc.delete();
      chk("rst_mid", {ide_dior, ide_diow, ide_cs, ide_da, ide_data_oe, ide_data_out, rdata, rvalid, wready, busy, done, timeout},
          {1'b1, 1'b1, 2'b11, 3'b111, 1'b0, 16'h0, 16'h0, 5'b0});
      repeat (5) tick();
      chk("rst_no_done", ndone - d0, 0);
      chk("rst_idle", busy, 0);

      // count=0 read performs one word
      ide_data_in = 16'h1234;
      rq.push_back(16'h1234);
      sq.push_back(3);
      r0 = nrv;
      start(0, 5'b00001, 8'd0);
      wait_done("cnt0_done_cyc", 7);
      repeat (3) tick();
      chk("cnt0_nrv", nrv - r0, 1);
      chk("cnt0_ndone", ndone - d0, 1);
      chk("cnt0_idle", busy, 0);

      chk("rq_left", rq.size(), 0);
      chk("sq_left", sq.size(), 0);
      chk("wq_left", wq.size(), 0);
      chk("wlq_left", wlq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
